// File: rtl/sine_phase_stepper.sv
// Phase-accumulating quarter-wave sine sample generator; optional PHASE_RESET_ON_CHANGE_EN restarts phase on step change.
// Latency: strobe in cycle N -> sample_ready in cycle N+3, one sample per cycle.
// Backpressure: none; every generate_next strobe yields exactly one sample_ready pulse unless reset intervenes.
module sine_phase_stepper #(
  parameter int STEP_W   = 20,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [STEP_W-1:0]   step_size,
  input  logic                generate_next,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready
);

  localparam int FRAC_W  = STEP_W - ADDR_W;
  localparam int PHASE_W = ADDR_W + 2 + FRAC_W;
  localparam logic [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef struct packed {
    logic vld;
    logic neg;
    logic mute;
  } meta_t;

  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phase_next;
  logic [PHASE_W-1:0]  step_ext;
  logic [ADDR_W-1:0]   idx_next;
  logic [SAMPLE_W-1:0] neg_data;
  meta_t               meta0;
  meta_t               meta1;

`ifdef PHASE_RESET_ON_CHANGE_EN
  logic [STEP_W-1:0]   last_step;
`endif

  always_comb begin
    step_ext   = {{(PHASE_W-STEP_W){1'b0}}, step_size};
    phase_next = phase + step_ext;
`ifdef PHASE_RESET_ON_CHANGE_EN
    if (step_size != last_step) phase_next = step_ext;
`endif
    // Odd quadrants read the quarter wave backwards.
    idx_next = phase_next[FRAC_W +: ADDR_W];
    if (phase_next[PHASE_W-2]) idx_next = ~idx_next;
  end

  always_comb begin
    neg_data = ~rom_data + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    if (rom_data == SMIN) neg_data = SMAX;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase        <= '0;
      rom_addr     <= '0;
      meta0        <= '0;
      meta1        <= '0;
      sample       <= '0;
      sample_ready <= 1'b0;
`ifdef PHASE_RESET_ON_CHANGE_EN
      last_step    <= '0;
`endif
    end else begin
      meta0.vld <= generate_next;
      if (generate_next) begin
        phase      <= phase_next;
        rom_addr   <= idx_next;
        meta0.neg  <= phase_next[PHASE_W-1];
        meta0.mute <= (step_size == '0);
`ifdef PHASE_RESET_ON_CHANGE_EN
        last_step  <= step_size;
`endif
      end
      meta1 <= meta0;
      sample_ready <= meta1.vld;
      if (meta1.vld) begin
        if (meta1.mute)     sample <= '0;
        else if (meta1.neg) sample <= neg_data;
        else                sample <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sine_phase_stepper.sv
// Directed bench for sine_phase_stepper with a registered ROM model returning addr*16 (or a forced word).
module tb_sine_phase_stepper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] step_size;
  logic        generate_next;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] sample;
  logic        sample_ready;

  logic        rom_force = 1'b0;
  logic [15:0] rom_val   = 16'h0000;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sine_phase_stepper dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step_size    (step_size),
    .generate_next(generate_next),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_ready (sample_ready)
  );

  always @(posedge clk) rom_data <= rom_force ? rom_val : {2'b00, rom_addr, 4'b0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  logic [9:0]  qa_addr [1:10];
  logic [15:0] qa_samp [1:10];
  logic [9:0]  tp_addr [1:4];
  logic [15:0] tp_samp [1:4];

  initial begin
    qa_addr = '{10'd256, 10'd512, 10'd768, 10'd1023, 10'd767, 10'd511, 10'd255, 10'd0, 10'd256, 10'd512};
    qa_samp = '{16'd4096, 16'd8192, 16'd12288, 16'd16368, 16'd12272, 16'd8176, 16'd4080,
                16'h0000, 16'hF000, 16'hE000};
    tp_addr = '{10'd0, 10'd1, 10'd1, 10'd2};
    tp_samp = '{16'd0, 16'd16, 16'd16, 16'd32};

    // Reset held two cycles with strobe high
    reset_n = 1'b0; generate_next = 1'b1; step_size = {10'd1, 10'd0};
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_addr", rom_addr, 0);
      check("rst_sample", sample, 0);
      check("rst_ready", sample_ready, 0);
    end
    reset_n = 1'b1; generate_next = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ready", sample_ready, 0);
    end

    // Basic read with latency
    step_size = {10'd1, 10'd0}; generate_next = 1'b1;
    tick();
    check("basic_addr", rom_addr, 1);
    check("basic_ready_n1", sample_ready, 0);
    generate_next = 1'b0;
    tick();
    check("basic_ready_n2", sample_ready, 0);
    tick();
    check("basic_ready_n3", sample_ready, 1);
    check("basic_sample", sample, 16);
    tick();
    check("basic_ready_n4", sample_ready, 0);
    check("basic_hold", sample, 16);

    // Quadrant folding and sign
    do_reset();
    step_size = {10'd256, 10'd0};
    for (int i = 1; i <= 12; i++) begin
      generate_next = (i <= 10);
      tick();
      if (i <= 10) check($sformatf("quad_addr%0d", i), rom_addr, qa_addr[i]);
      if (i >= 3) begin
        check($sformatf("quad_ready%0d", i - 2), sample_ready, 1);
        check($sformatf("quad_sample%0d", i - 2), sample, qa_samp[i - 2]);
      end else begin
        check("quad_ready_early", sample_ready, 0);
      end
    end

    // Negation and saturation in quadrant 2/3
    rom_force = 1'b1; rom_val = 16'h4000;
    generate_next = 1'b1;
    tick();
    generate_next = 1'b0;
    tick(); tick();
    check("neg_ready", sample_ready, 1);
    check("neg_sample", sample, 16'hC000);
    rom_val = 16'h8000;
    generate_next = 1'b1;
    tick();
    generate_next = 1'b0;
    tick(); tick();
    check("sat_ready", sample_ready, 1);
    check("sat_sample", sample, 16'h7FFF);
    rom_force = 1'b0;

    // Throughput with fractional step
    do_reset();
    step_size = {10'd0, 10'd512};
    for (int i = 1; i <= 6; i++) begin
      generate_next = (i <= 4);
      tick();
      if (i <= 4) check($sformatf("tp_addr%0d", i), rom_addr, tp_addr[i]);
      if (i >= 3) begin
        check($sformatf("tp_ready%0d", i - 2), sample_ready, 1);
        check($sformatf("tp_sample%0d", i - 2), sample, tp_samp[i - 2]);
      end
    end
    tick();
    check("tp_ready_end", sample_ready, 0);

    // Rest strobe
    step_size = '0; generate_next = 1'b1;
    tick();
`ifdef PHASE_RESET_ON_CHANGE_EN
    check("rest_addr", rom_addr, 0);
`else
    check("rest_addr", rom_addr, 2);
`endif
    generate_next = 1'b0;
    tick(); tick();
    check("rest_ready", sample_ready, 1);
    check("rest_sample", sample, 0);

    // Reset one cycle after a strobe aborts the sample
    step_size = {10'd1, 10'd0}; generate_next = 1'b1;
    tick();
    generate_next = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_addr", rom_addr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_ready", sample_ready, 0);
    end

    // Step change mid-note
    step_size = {10'd5, 10'd0}; generate_next = 1'b1;
    tick();
    check("chg_addr1", rom_addr, 5);
    tick();
    check("chg_addr2", rom_addr, 10);
    step_size = {10'd3, 10'd0};
    tick();
`ifdef PHASE_RESET_ON_CHANGE_EN
    check("chg_addr3", rom_addr, 3);
`else
    check("chg_addr3", rom_addr, 13);
`endif
    generate_next = 1'b0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
